// File: rtl/hd44780_responder.sv
// Behavioral HD44780 LCD model: decodes the 8-bit rs/rw/enable bus, keeps an
// 80-byte DDRAM with address counter, display-control state and busy timing.
module hd44780_responder #(
  parameter int unsigned BUSY_SHORT = 2000,
  parameter int unsigned BUSY_LONG  = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       enable,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       busy,
  output logic       err_busy,
  output logic       err_cfg
);

  localparam int unsigned CNT_W      = $clog2(BUSY_LONG + 1);
  localparam int unsigned DDRAM_N    = 80;
  localparam int unsigned SWEEP_LAST = DDRAM_N - 1;
  localparam int unsigned LONG_REM   = (BUSY_LONG > DDRAM_N) ? BUSY_LONG - DDRAM_N - 1 : 0;

  typedef enum logic [1:0] {CLR_SWEEP, IDLE, BUSY} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [6:0]         sweep_idx, sweep_n;
  logic               sweep_cmd, sweep_cmd_n;
  logic               busy_n;

  logic               s1_en, s2_en, en_q;
  logic               s1_rs, s2_rs, s1_rw, s2_rw;
  logic [7:0]         s1_d, s2_d;

  logic [6:0]         ac;
  logic               inc;
  logic [7:0]         mem [DDRAM_N];

  logic               fall_c, accept_c, wr_c, wr_ok_c, wr_drop_c;
  logic               cmd_c, data_wr_c, rd_step_c;
  logic               is_nop_c, is_home_c, is_clear_c;
  logic [7:0]         ac_char_c;

  function automatic logic addr_valid(input logic [6:0] a, input logic two);
    if (two) return (a < 7'h28) || ((a >= 7'h40) && (a < 7'h68));
    return a < 7'h50;
  endfunction

  // Line 2 (0x40-0x67) occupies storage 40-79 in two-line mode.
  function automatic logic [6:0] addr_idx(input logic [6:0] a, input logic two);
    return (two && (a >= 7'h40)) ? a - 7'd24 : a;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up, input logic two);
    if (two) begin
      if (up)  return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
      return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    end
    if (up) return (a == 7'h4F) ? 7'h00 : a + 7'd1;
    return (a == 7'h00) ? 7'h4F : a - 7'd1;
  endfunction

  // Two-stage synchronizer on the whole bus plus enable edge register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_en <= 1'b0; s2_en <= 1'b0; en_q <= 1'b0;
      s1_rs <= 1'b0; s2_rs <= 1'b0;
      s1_rw <= 1'b0; s2_rw <= 1'b0;
      s1_d  <= 8'h00; s2_d <= 8'h00;
    end else begin
      s1_en <= enable;  s2_en <= s1_en; en_q <= s2_en;
      s1_rs <= rs;      s2_rs <= s1_rs;
      s1_rw <= rw;      s2_rw <= s1_rw;
      s1_d  <= data_in; s2_d  <= s1_d;
    end
  end

  assign fall_c     = en_q & ~s2_en;
  assign accept_c   = (state == IDLE) || ((state == BUSY) && (cnt == '0));
  assign wr_c       = fall_c & ~s2_rw;
  assign wr_ok_c    = wr_c & accept_c;
  assign wr_drop_c  = wr_c & ~accept_c;
  assign cmd_c      = wr_ok_c & ~s2_rs;
  assign data_wr_c  = wr_ok_c & s2_rs;
  assign rd_step_c  = fall_c & s2_rw & s2_rs;
  assign is_nop_c   = (s2_d == 8'h00);
  assign is_clear_c = (s2_d == 8'h01);
  assign is_home_c  = (s2_d[7:1] == 7'h01);

  assign ac_char_c   = addr_valid(ac, two_line) ? mem[addr_idx(ac, two_line)] : 8'h20;
  assign rd_char     = addr_valid(rd_addr, two_line) ? mem[addr_idx(rd_addr, two_line)] : 8'h20;
  assign cursor_addr = ac;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLR_SWEEP;
      cnt       <= '0;
      sweep_idx <= '0;
      sweep_cmd <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sweep_idx <= sweep_n;
      sweep_cmd <= sweep_cmd_n;
      busy      <= busy_n;
    end
  end

  // Next state: sweep/countdown progress, overridden by an accepted write.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sweep_n     = sweep_idx;
    sweep_cmd_n = sweep_cmd;
    case (state)
      CLR_SWEEP: begin
        sweep_n = sweep_idx + 7'd1;
        if (sweep_idx == 7'(SWEEP_LAST)) begin
          sweep_n     = '0;
          sweep_cmd_n = 1'b0;
          if (sweep_cmd && (BUSY_LONG > DDRAM_N)) begin
            state_n = BUSY;
            cnt_n   = CNT_W'(LONG_REM);
          end else begin
            state_n = IDLE;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: ;
    endcase
    if (data_wr_c || (cmd_c && !is_nop_c)) begin
      state_n = BUSY;
      cnt_n   = CNT_W'(BUSY_SHORT - 1);
      if (cmd_c && is_home_c) cnt_n = CNT_W'(BUSY_LONG - 1);
      if (cmd_c && is_clear_c) begin
        state_n     = CLR_SWEEP;
        sweep_n     = '0;
        sweep_cmd_n = 1'b1;
      end
    end
    busy_n = (state_n != IDLE);
  end

  // Address counter, mode bits, read port and error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ac         <= '0;
      inc        <= 1'b1;
      two_line   <= 1'b0;
      display_on <= 1'b0;
      cursor_on  <= 1'b0;
      blink_on   <= 1'b0;
      err_busy   <= 1'b0;
      err_cfg    <= 1'b0;
      data_out   <= 8'h00;
      data_oe    <= 1'b0;
    end else begin
      err_busy <= wr_drop_c;
      err_cfg  <= 1'b0;
      data_oe  <= s1_en & s1_rw;
      data_out <= s2_rs ? ac_char_c : {busy, ac};
      if (data_wr_c || rd_step_c) begin
        ac <= ac_step(ac, inc, two_line);
      end else if (cmd_c) begin
        casez (s2_d)
          8'b1???????: begin
            if (addr_valid(s2_d[6:0], two_line)) ac <= s2_d[6:0];
            else begin
              ac      <= '0;
              err_cfg <= 1'b1;
            end
          end
          8'b01??????: ;
          8'b001?????: begin
            two_line <= s2_d[3];
            if (!s2_d[4]) err_cfg <= 1'b1;
          end
          8'b0001????: if (!s2_d[3]) ac <= ac_step(ac, s2_d[2], two_line);
          8'b00001???: {display_on, cursor_on, blink_on} <= s2_d[2:0];
          8'b000001??: inc <= s2_d[1];
          8'b0000001?: ac <= '0;
          8'b00000001: begin
            ac  <= '0;
            inc <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // DDRAM: clear sweep has priority; writes are never accepted during it.
  always_ff @(posedge clk) begin
    if (state == CLR_SWEEP) mem[sweep_idx] <= 8'h20;
    else if (data_wr_c && addr_valid(ac, two_line)) mem[addr_idx(ac, two_line)] <= s2_d;
  end

endmodule

// File: tb/tb_hd44780_responder.sv
// Directed bench for hd44780_responder: init sequence, DDRAM writes, AC wrap,
// error pulses, status/data reads and reset during the clear sweep.
module tb_hd44780_responder;

  localparam int unsigned BS = 20;
  localparam int unsigned BL = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rs = 1'b0, rw = 1'b0, enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] data_out, rd_char;
  logic [6:0] cursor_addr;
  logic       data_oe, display_on, cursor_on, blink_on, two_line, busy, err_busy, err_cfg;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cfg   = 0;
  int n_ebusy = 0;

  hd44780_responder #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .rd_addr(rd_addr), .rd_char(rd_char),
    .cursor_addr(cursor_addr), .display_on(display_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .two_line(two_line), .busy(busy), .err_busy(err_busy),
    .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_cfg)  n_cfg++;
    if (err_busy) n_ebusy++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic r, input logic [7:0] d);
    @(negedge clk);
    rs = r; rw = 1'b0; data_in = d; enable = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(input int max, input string tag);
    int i = 0;
    while (busy && i < max) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(busy), 0);
  endtask

  task automatic send(input logic r, input logic [7:0] d);
    xfer(r, d);
    wait_idle(BL + 50, "idle_timeout");
  endtask

  // Checks busy rises on the 3rd edge after the fall and stays up exp_len cycles.
  task automatic timed_xfer(input logic r, input logic [7:0] d, input int exp_len, input string tag);
    int len;
    @(negedge clk);
    rs = r; rw = 1'b0; data_in = d; enable = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_lat_lo"}, 32'(busy), 0);
    @(negedge clk);
    check({tag, "_lat_hi"}, 32'(busy), 1);
    len = 1;
    while (busy && len < exp_len + 20) begin
      @(negedge clk);
      if (busy) len++;
    end
    check({tag, "_len"}, 32'(len), 32'(exp_len));
  endtask

  task automatic get_char(input logic [6:0] a, output logic [7:0] c);
    rd_addr = a;
    #1;
    c = rd_char;
  endtask

  task automatic check_blank(input logic two, input string tag);
    int bad = 0;
    for (int i = 0; i < 80; i++) begin
      rd_addr = (two && i >= 40) ? 7'(i + 24) : 7'(i);
      #1;
      if (rd_char !== 8'h20) bad++;
    end
    check(tag, 32'(bad), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    int         n0;

    repeat (3) @(negedge clk);
    check("rst_flags", {busy, data_oe, display_on, cursor_on, blink_on, two_line, err_busy, err_cfg}, 8'h80);
    check("rst_ac", 32'(cursor_addr), 0);
    check("rst_dout", 32'(data_out), 0);
    reset = 1'b0;
    wait_idle(100, "rst_sweep");
    check_blank(1'b0, "rst_blank");

    // Power-up init sequence
    repeat (4) send(1'b0, 8'h38);
    send(1'b0, 8'h0C);
    timed_xfer(1'b0, 8'h01, BL, "clear");
    send(1'b0, 8'h06);
    check("init_mode", {two_line, display_on, cursor_on, blink_on}, 4'b1100);
    check("init_ac", 32'(cursor_addr), 0);

    // Data writes
    timed_xfer(1'b1, 8'h53, BS, "dwr");
    send(1'b1, 8'h31);
    send(1'b1, 8'h3A);
    get_char(7'h00, c); check("ch00", 32'(c), 32'h53);
    get_char(7'h01, c); check("ch01", 32'(c), 32'h31);
    get_char(7'h02, c); check("ch02", 32'(c), 32'h3A);
    check("ac_after_str", 32'(cursor_addr), 3);

    // Line 2 addressing
    send(1'b0, 8'hC0);
    check("ac_line2", 32'(cursor_addr), 32'h40);
    send(1'b1, 8'h41);
    check("ac_line2_inc", 32'(cursor_addr), 32'h41);
    get_char(7'h40, c); check("ch40", 32'(c), 32'h41);

    // AC wrap and shifts
    send(1'b0, 8'hA7);
    send(1'b1, 8'h42);
    check("wrap_27_40", 32'(cursor_addr), 32'h40);
    get_char(7'h27, c); check("ch27", 32'(c), 32'h42);
    send(1'b0, 8'h04);
    send(1'b0, 8'h80);
    send(1'b1, 8'h5A);
    check("wrap_00_67", 32'(cursor_addr), 32'h67);
    get_char(7'h00, c); check("ch00_ovr", 32'(c), 32'h5A);
    send(1'b0, 8'h10);
    check("shift_left", 32'(cursor_addr), 32'h66);
    send(1'b0, 8'h14);
    send(1'b0, 8'h14);
    check("shift_right_wrap", 32'(cursor_addr), 32'h00);
    send(1'b0, 8'h85);
    n0 = n_cfg;
    send(1'b0, 8'hB0);
    check("bad_addr_ac", 32'(cursor_addr), 0);
    check("bad_addr_errcfg", 32'(n_cfg - n0), 1);
    get_char(7'h30, c); check("ch30_invalid", 32'(c), 32'h20);
    n0 = n_cfg;
    send(1'b0, 8'h28);
    check("dl0_errcfg", 32'(n_cfg - n0), 1);
    check("dl0_keeps_n", 32'(two_line), 1);
    send(1'b0, 8'h06);

    // Write while busy is dropped
    n0 = n_ebusy;
    xfer(1'b0, 8'h01);
    xfer(1'b1, 8'h77);
    wait_idle(BL + 50, "clr2_idle");
    check("err_busy_pulse", 32'(n_ebusy - n0), 1);
    check_blank(1'b1, "clr2_blank");
    check("clr2_ac", 32'(cursor_addr), 0);

    // Data read steps AC
    send(1'b1, 8'h51);
    send(1'b0, 8'h80);
    @(negedge clk);
    rs = 1'b1; rw = 1'b1; enable = 1'b1;
    repeat (4) @(negedge clk);
    check("rd_data", 32'(data_out), 32'h51);
    check("rd_oe", 32'(data_oe), 1);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    check("rd_ac_step", 32'(cursor_addr), 1);
    rw = 1'b0;

    // Status read while busy
    send(1'b0, 8'h84);
    xfer(1'b0, 8'h14);
    rs = 1'b0; rw = 1'b1; enable = 1'b1;
    repeat (4) @(negedge clk);
    check("status_oe", 32'(data_oe), 1);
    check("status_busy", 32'(data_out), 32'h85);
    wait_idle(BL + 50, "status_idle");
    @(negedge clk);
    @(negedge clk);
    check("status_idle_val", 32'(data_out), 32'h05);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    check("status_oe_off", 32'(data_oe), 0);
    rw = 1'b0;

    // Reset in the middle of a clear sweep
    send(1'b1, 8'h41);
    xfer(1'b0, 8'h01);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_state", {busy, two_line, display_on}, 3'b100);
    reset = 1'b0;
    wait_idle(100, "midrst_idle");
    check_blank(1'b0, "midrst_blank");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
